// File: rtl/processor_dispatcher_pkg.sv
// Shared types for the processor dispatcher: FSM states, result payload and
// default field widths.
package processor_dispatcher_pkg;

    localparam int unsigned XBITS_DEF     = 10;
    localparam int unsigned YBITS_DEF     = 10;
    localparam int unsigned SCALEBITS_DEF = 5;
    localparam int unsigned FIXEDBITS_DEF = 32;
    localparam int unsigned STAGEBITS_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VAR_REQ,
        ST_VAR_GUARD,
        ST_VAR_WAIT,
        ST_RUN_REQ,
        ST_RUN_WAIT,
        ST_RESULT
    } state_t;

    // Result payload handed to the detection-output stage (default widths).
    typedef struct packed {
        logic                     passfail;
        logic [XBITS_DEF-1:0]     x;
        logic [YBITS_DEF-1:0]     y;
        logic [SCALEBITS_DEF-1:0] scale;
    } processor_dispatcher_result_t;

endpackage

// File: rtl/dispatcher_buffer_tracker.sv
// Tracks occupancy of the two window-cache buffers and their metadata.
// Ports: fill_* from the loader, rel_en/rel_buf release a buffer, sel_buf
// picks the metadata presented on sel_*_c; full/fill_buf/err_overflow are
// registered, fill_ready_c is decoded.
module dispatcher_buffer_tracker
    import processor_dispatcher_pkg::*;
#(
    parameter int unsigned XBITS     = XBITS_DEF,
    parameter int unsigned YBITS     = YBITS_DEF,
    parameter int unsigned SCALEBITS = SCALEBITS_DEF,
    parameter int unsigned FIXEDBITS = FIXEDBITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fill_done,
    input  logic [XBITS-1:0]     fill_x,
    input  logic [YBITS-1:0]     fill_y,
    input  logic [SCALEBITS-1:0] fill_scale,
    input  logic [FIXEDBITS-1:0] fill_inv_area,
    input  logic                 rel_en,
    input  logic                 rel_buf,
    input  logic                 sel_buf,
    output logic [1:0]           full,
    output logic                 fill_buf,
    output logic                 fill_ready_c,
    output logic [XBITS-1:0]     sel_x_c,
    output logic [YBITS-1:0]     sel_y_c,
    output logic [SCALEBITS-1:0] sel_scale_c,
    output logic [FIXEDBITS-1:0] sel_inv_area_c,
    output logic                 err_overflow
);

    logic [XBITS-1:0]     meta_x   [2];
    logic [YBITS-1:0]     meta_y   [2];
    logic [SCALEBITS-1:0] meta_sc  [2];
    logic [FIXEDBITS-1:0] meta_inv [2];
    logic                 accept_c;

    assign fill_ready_c   = ~full[fill_buf];
    assign accept_c       = fill_done & fill_ready_c;
    assign sel_x_c        = meta_x[sel_buf];
    assign sel_y_c        = meta_y[sel_buf];
    assign sel_scale_c    = meta_sc[sel_buf];
    assign sel_inv_area_c = meta_inv[sel_buf];

    // Release and fill never target the same buffer, so the two writes to
    // full are independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full         <= 2'b00;
            fill_buf     <= 1'b0;
            err_overflow <= 1'b0;
            meta_x[0]    <= '0;
            meta_x[1]    <= '0;
            meta_y[0]    <= '0;
            meta_y[1]    <= '0;
            meta_sc[0]   <= '0;
            meta_sc[1]   <= '0;
            meta_inv[0]  <= '0;
            meta_inv[1]  <= '0;
        end else begin
            if (rel_en) begin
                full[rel_buf] <= 1'b0;
            end
            if (accept_c) begin
                full[fill_buf]     <= 1'b1;
                meta_x[fill_buf]   <= fill_x;
                meta_y[fill_buf]   <= fill_y;
                meta_sc[fill_buf]  <= fill_scale;
                meta_inv[fill_buf] <= fill_inv_area;
                fill_buf           <= ~fill_buf;
            end
            if (fill_done & ~fill_ready_c) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/processor_dispatcher.sv
// Initiator of the processor control protocol: for each filled buffer runs
// variance setup, detection and result collection, forwards results and
// releases the buffer. Ports: loader side (fill_*), processor side (proc_*),
// result slot (res_*), statistics (stat_*) and err_overflow.
module processor_dispatcher
    import processor_dispatcher_pkg::*;
#(
    parameter int unsigned XBITS         = XBITS_DEF,
    parameter int unsigned YBITS         = YBITS_DEF,
    parameter int unsigned SCALEBITS     = SCALEBITS_DEF,
    parameter int unsigned FIXEDBITS     = FIXEDBITS_DEF,
    parameter int unsigned STAGEBITS     = STAGEBITS_DEF,
    parameter bit          FORWARD_FAILS = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STAGEBITS-1:0] cfg_num_stages,
    output logic                 fill_buf,
    output logic                 fill_ready,
    input  logic                 fill_done,
    input  logic [XBITS-1:0]     fill_x,
    input  logic [YBITS-1:0]     fill_y,
    input  logic [SCALEBITS-1:0] fill_scale,
    input  logic [FIXEDBITS-1:0] fill_inv_area,
    output logic                 proc_startVar,
    input  logic                 proc_readyVar,
    output logic                 proc_start,
    input  logic                 proc_ready,
    input  logic                 proc_done,
    input  logic                 proc_valid,
    input  logic                 proc_passfail,
    output logic                 proc_taken,
    output logic                 proc_dblBuf,
    output logic [STAGEBITS-1:0] proc_numberOfStages,
    output logic [FIXEDBITS-1:0] proc_inv_window_area,
    output logic                 res_valid,
    output logic                 res_passfail,
    output logic [XBITS-1:0]     res_x,
    output logic [YBITS-1:0]     res_y,
    output logic [SCALEBITS-1:0] res_scale,
    input  logic                 res_taken,
    output logic [15:0]          stat_windows,
    output logic [15:0]          stat_passed,
    output logic                 err_overflow
);

    state_t               state, state_next;
    logic                 cur_buf;
    logic [1:0]           full;
    logic                 fill_ready_c;
    logic                 taken_c, drop_c, slot_free_c, load_c;
    logic [XBITS-1:0]     sel_x_c;
    logic [YBITS-1:0]     sel_y_c;
    logic [SCALEBITS-1:0] sel_scale_c;
    logic [FIXEDBITS-1:0] sel_inv_area_c;

    dispatcher_buffer_tracker #(
        .XBITS     (XBITS),
        .YBITS     (YBITS),
        .SCALEBITS (SCALEBITS),
        .FIXEDBITS (FIXEDBITS)
    ) u_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .fill_done      (fill_done),
        .fill_x         (fill_x),
        .fill_y         (fill_y),
        .fill_scale     (fill_scale),
        .fill_inv_area  (fill_inv_area),
        .rel_en         (taken_c),
        .rel_buf        (cur_buf),
        .sel_buf        (cur_buf),
        .full           (full),
        .fill_buf       (fill_buf),
        .fill_ready_c   (fill_ready_c),
        .sel_x_c        (sel_x_c),
        .sel_y_c        (sel_y_c),
        .sel_scale_c    (sel_scale_c),
        .sel_inv_area_c (sel_inv_area_c),
        .err_overflow   (err_overflow)
    );

    assign fill_ready  = fill_ready_c;
    assign proc_taken  = taken_c;
    assign proc_dblBuf = cur_buf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and result handshake.
    always_comb begin
        state_next  = state;
        taken_c     = 1'b0;
        drop_c      = ~proc_passfail & ~FORWARD_FAILS;
        slot_free_c = ~res_valid | res_taken;
        case (state)
            ST_IDLE:      if (full[cur_buf]) state_next = ST_VAR_REQ;
            ST_VAR_REQ:   if (proc_readyVar) state_next = ST_VAR_GUARD;
            // The processor lowers readyVar during this cycle; ignore it.
            ST_VAR_GUARD: state_next = ST_VAR_WAIT;
            ST_VAR_WAIT:  if (proc_readyVar) state_next = ST_RUN_REQ;
            ST_RUN_REQ:   if (proc_ready) state_next = ST_RUN_WAIT;
            ST_RUN_WAIT:  if (proc_done) state_next = ST_RESULT;
            ST_RESULT: begin
                taken_c = proc_valid & (drop_c | slot_free_c);
                if (taken_c) state_next = ST_IDLE;
            end
            default:      state_next = ST_IDLE;
        endcase
        load_c = taken_c & ~drop_c;
    end

    // Registered requests, latched window parameters, result slot, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_startVar        <= 1'b0;
            proc_start           <= 1'b0;
            proc_numberOfStages  <= '0;
            proc_inv_window_area <= '0;
            cur_buf              <= 1'b0;
            res_valid            <= 1'b0;
            res_passfail         <= 1'b0;
            res_x                <= '0;
            res_y                <= '0;
            res_scale            <= '0;
            stat_windows         <= 16'd0;
            stat_passed          <= 16'd0;
        end else begin
            proc_startVar <= (state_next == ST_VAR_REQ);
            proc_start    <= (state_next == ST_RUN_REQ);
            if (state == ST_VAR_REQ && proc_readyVar) begin
                proc_numberOfStages <= cfg_num_stages;
            end
            if (state == ST_IDLE && state_next == ST_VAR_REQ) begin
                proc_inv_window_area <= sel_inv_area_c;
            end
            if (taken_c) begin
                cur_buf      <= ~cur_buf;
                stat_windows <= stat_windows + 16'd1;
                if (proc_passfail) stat_passed <= stat_passed + 16'd1;
            end
            if (load_c) begin
                res_valid    <= 1'b1;
                res_passfail <= proc_passfail;
                res_x        <= sel_x_c;
                res_y        <= sel_y_c;
                res_scale    <= sel_scale_c;
            end else if (res_taken) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_processor_dispatcher.sv
// Self-checking bench for processor_dispatcher: directed loader/downstream
// stimulus, a reactive processor model, and a window-queue reference model.
module tb_processor_dispatcher;

    logic        clk, rst_n;
    logic [4:0]  cfg_num_stages;
    logic        fill_buf, fill_ready, fill_done;
    logic [9:0]  fill_x, fill_y;
    logic [4:0]  fill_scale;
    logic [31:0] fill_inv_area;
    logic        proc_startVar, proc_readyVar, proc_start, proc_ready;
    logic        proc_done, proc_valid, proc_passfail, proc_taken, proc_dblBuf;
    logic [4:0]  proc_numberOfStages;
    logic [31:0] proc_inv_window_area;
    logic        res_valid, res_passfail, res_taken, err_overflow;
    logic [9:0]  res_x, res_y;
    logic [4:0]  res_scale;
    logic [15:0] stat_windows, stat_passed;

    processor_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .cfg_num_stages(cfg_num_stages),
        .fill_buf(fill_buf), .fill_ready(fill_ready), .fill_done(fill_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_scale(fill_scale),
        .fill_inv_area(fill_inv_area),
        .proc_startVar(proc_startVar), .proc_readyVar(proc_readyVar),
        .proc_start(proc_start), .proc_ready(proc_ready), .proc_done(proc_done),
        .proc_valid(proc_valid), .proc_passfail(proc_passfail),
        .proc_taken(proc_taken), .proc_dblBuf(proc_dblBuf),
        .proc_numberOfStages(proc_numberOfStages),
        .proc_inv_window_area(proc_inv_window_area),
        .res_valid(res_valid), .res_passfail(res_passfail), .res_x(res_x),
        .res_y(res_y), .res_scale(res_scale), .res_taken(res_taken),
        .stat_windows(stat_windows), .stat_passed(stat_passed),
        .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: windows as a FIFO of at most two ----
    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [4:0]  s;
        logic [31:0] inv;
    } win_t;

    win_t        q[$];
    win_t        h;
    win_t        m_res;
    logic        m_res_pf;
    int          m_fills, m_rel, m_windows, m_passed;
    logic        m_rv, m_ovf;
    logic [4:0]  m_stages;
    logic        e_taken, e_drop;
    logic        hs_var, hs_run, hs_taken;
    int          sv_cyc = 0;
    int          st_cyc = 0;
    int          occ;

    initial begin
        q.delete();
        m_fills = 0; m_rel = 0; m_windows = 0; m_passed = 0;
        m_rv = 0; m_ovf = 0; m_stages = '0; m_res_pf = 0;
        hs_var = 0; hs_run = 0; hs_taken = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                q.delete();
                m_fills = 0; m_rel = 0; m_windows = 0; m_passed = 0;
                m_rv = 0; m_ovf = 0; m_stages = '0;
                chk("rst_startvar", proc_startVar, 0);
                chk("rst_start", proc_start, 0);
                chk("rst_stages", proc_numberOfStages, 0);
                chk("rst_inv_area", proc_inv_window_area, 0);
                chk("rst_res_fields", {res_passfail, res_x, res_y, res_scale}, 0);
            end
            e_drop  = !proc_passfail;
            e_taken = rst_n && proc_valid && (e_drop || !m_rv || res_taken);
            chk("fill_ready", fill_ready, q.size() < 2);
            chk("fill_buf", fill_buf, m_fills % 2);
            chk("dblbuf", proc_dblBuf, m_rel % 2);
            chk("taken", proc_taken, e_taken);
            chk("res_valid", res_valid, m_rv);
            if (m_rv) begin
                chk("res_fields", {res_passfail, res_x, res_y, res_scale},
                    {m_res_pf, m_res.x, m_res.y, m_res.s});
            end
            chk("stat_windows", stat_windows, 16'(m_windows));
            chk("stat_passed", stat_passed, 16'(m_passed));
            chk("err_overflow", err_overflow, m_ovf);
            if (q.size() == 0) begin
                chk("request_without_window", proc_startVar | proc_start, 0);
            end else if (proc_startVar || proc_start) begin
                chk("inv_area", proc_inv_window_area, q[0].inv);
            end
            if (proc_start) chk("num_stages", proc_numberOfStages, m_stages);
            if (proc_startVar) sv_cyc++;
            if (proc_start) st_cyc++;
            hs_var   = proc_startVar & proc_readyVar;
            hs_run   = proc_start & proc_ready;
            hs_taken = proc_taken;
            // effects of the coming clock edge
            if (rst_n) begin
                occ = q.size();
                if (e_taken && q.size() > 0) begin
                    h = q.pop_front();
                    m_rel++;
                    m_windows++;
                    if (proc_passfail) m_passed++;
                end
                if (m_rv && res_taken) m_rv = 0;
                if (e_taken && !e_drop) begin
                    m_rv = 1; m_res = h; m_res_pf = proc_passfail;
                end
                if (fill_done) begin
                    if (occ < 2) begin
                        q.push_back('{fill_x, fill_y, fill_scale, fill_inv_area});
                        m_fills++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (hs_var) m_stages = cfg_num_stages;
            end
        end
    end

    // ---------------- reactive processor ------------------------------------
    typedef enum {B_IDLE, B_VBUSY, B_RIDLE, B_RBUSY, B_RDONE, B_RWAIT} bst_t;
    bst_t bst;
    int   cnt;
    int   var_lat = 2;
    int   run_lat = 3;
    logic pf_q[$];

    initial begin
        proc_readyVar = 1; proc_ready = 1; proc_done = 0;
        proc_valid = 0; proc_passfail = 0; bst = B_IDLE; cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                proc_readyVar = 1; proc_ready = 1; proc_done = 0;
                proc_valid = 0; proc_passfail = 0; bst = B_IDLE;
                pf_q.delete();
            end else begin
                case (bst)
                    B_IDLE: if (hs_var) begin
                        proc_readyVar = 0; cnt = var_lat; bst = B_VBUSY;
                    end
                    B_VBUSY: if (cnt == 0) begin
                        proc_readyVar = 1; bst = B_RIDLE;
                    end else cnt--;
                    B_RIDLE: if (hs_run) begin
                        proc_ready = 0; cnt = run_lat; bst = B_RBUSY;
                    end
                    B_RBUSY: if (cnt == 0) begin
                        proc_done = 1; bst = B_RDONE;
                    end else cnt--;
                    B_RDONE: begin
                        proc_done = 0; proc_valid = 1;
                        proc_passfail = (pf_q.size() > 0) ? pf_q.pop_front() : 1'b1;
                        bst = B_RWAIT;
                    end
                    B_RWAIT: if (hs_taken) begin
                        proc_valid = 0; proc_passfail = 0; proc_ready = 1; bst = B_IDLE;
                    end
                    default: bst = B_IDLE;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic fill(input logic [9:0] x, input logic [9:0] y,
                        input logic [4:0] s, input logic [31:0] inv);
        @(negedge clk);
        fill_done = 1; fill_x = x; fill_y = y; fill_scale = s; fill_inv_area = inv;
        @(negedge clk);
        fill_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; fill_done = 0; res_taken = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic consume();
        @(negedge clk); res_taken = 1;
        @(negedge clk); res_taken = 0;
    endtask

    task automatic wait_windows(input int n);
        logic got;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #3;
            if (m_windows >= n) begin got = 1; break; end
        end
        chk("wait_windows_timeout", got, 1);
        @(negedge clk); #3;
    endtask

    // ---------------- directed tests -----------------------------------------
    initial begin
        logic got;
        rst_n = 0; fill_done = 0; res_taken = 0; cfg_num_stages = 5'd9;
        fill_x = '0; fill_y = '0; fill_scale = '0; fill_inv_area = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_fill_ready", fill_ready, 1);
        chk("reset_outputs", {fill_buf, proc_startVar, proc_start, proc_dblBuf,
                              res_valid, err_overflow, stat_windows, stat_passed}, 0);
        @(negedge clk); rst_n = 1;

        // single passing window, start latency and stage latching
        pf_q.push_back(1'b1);
        fill(10'd5, 10'd7, 5'd2, 32'h1234);
        #3 chk("t1_startvar_c1", proc_startVar, 0);
        @(negedge clk); #3 chk("t1_startvar_c2", proc_startVar, 1);
        chk("t1_inv_area", proc_inv_window_area, 32'h1234);
        @(negedge clk); cfg_num_stages = 5'd3;
        #3 chk("t1_startvar_one_cycle", proc_startVar, 0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (proc_start) begin got = 1; break; end
        end
        chk("t1_start_seen", got, 1);
        chk("t1_stages_latched", proc_numberOfStages, 9);
        wait_windows(1);
        chk("t1_res", {res_valid, res_passfail, res_x, res_y, res_scale},
            {1'b1, 1'b1, 10'd5, 10'd7, 5'd2});
        chk("t1_stats", {stat_windows, stat_passed}, {16'd1, 16'd1});
        consume();
        #3 chk("t1_slot_freed", res_valid, 0);

        // failing window is dropped
        do_reset();
        pf_q.push_back(1'b0);
        fill(10'd9, 10'd3, 5'd1, 32'h99);
        wait_windows(1);
        chk("t2_res_valid", res_valid, 0);
        chk("t2_stats", {stat_windows, stat_passed}, {16'd1, 16'd0});

        // double buffering with a downstream stall
        do_reset();
        pf_q.push_back(1'b1); pf_q.push_back(1'b1);
        #3 chk("t3_fill_buf0", fill_buf, 0);
        fill(10'd20, 10'd21, 5'd4, 32'h20);
        #3 chk("t3_fill_buf1", fill_buf, 1);
        fill(10'd30, 10'd31, 5'd5, 32'h30);
        #3 chk("t3_fill_buf2", {fill_buf, fill_ready}, 2'b00);
        wait_windows(1);
        chk("t3_first_res", {res_x, res_y, res_scale}, {10'd20, 10'd21, 5'd4});
        chk("t3_dblbuf1", proc_dblBuf, 1);
        repeat (25) @(negedge clk);
        #3;
        chk("t4_stalled_windows", stat_windows, 1);
        chk("t4_stalled_taken", proc_taken, 0);
        chk("t4_slot_held", {res_valid, res_x, res_y}, {1'b1, 10'd20, 10'd21});
        chk("t4_buf0_released", fill_ready, 1);
        consume();
        wait_windows(2);
        chk("t4_second_res", {res_valid, res_x, res_y, res_scale},
            {1'b1, 10'd30, 10'd31, 5'd5});
        chk("t4_stats", {stat_windows, stat_passed}, {16'd2, 16'd2});
        consume();

        // overflow while both buffers are full
        do_reset();
        run_lat = 6;
        pf_q.push_back(1'b1); pf_q.push_back(1'b1);
        fill(10'd1, 10'd2, 5'd3, 32'hA);
        fill(10'd4, 10'd5, 5'd6, 32'hB);
        fill(10'd7, 10'd8, 5'd9, 32'hC);
        #3 chk("t5_overflow", {err_overflow, fill_ready}, 2'b10);
        wait_windows(1);
        chk("t5_first_res", res_x, 10'd1);
        consume();
        wait_windows(2);
        chk("t5_meta_kept", {res_x, res_y, res_scale}, {10'd4, 10'd5, 5'd6});
        consume();
        repeat (30) @(negedge clk);
        #3 chk("t5_no_extra", {stat_windows, fill_ready, err_overflow}, {16'd2, 1'b1, 1'b1});

        // reset in the middle of detection
        do_reset();
        run_lat = 10;
        pf_q.push_back(1'b1);
        fill(10'd40, 10'd41, 5'd7, 32'h40);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (bst == B_RBUSY) begin got = 1; break; end
        end
        chk("t6_reached_run", got, 1);
        @(negedge clk); rst_n = 0;
        #3;
        chk("t6_reset_outputs", {proc_startVar, proc_start, proc_dblBuf, res_valid,
                                 err_overflow, stat_windows, stat_passed, fill_buf}, 0);
        chk("t6_reset_fill_ready", fill_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_lat = 2;
        pf_q.push_back(1'b1);
        fill(10'd11, 10'd12, 5'd3, 32'h11);
        @(negedge clk); #3;
        chk("t6_restart", {proc_startVar, proc_dblBuf, proc_inv_window_area},
            {1'b1, 1'b0, 32'h11});
        wait_windows(1);
        chk("t6_res", {res_valid, res_x, res_y, res_scale, stat_windows},
            {1'b1, 10'd11, 10'd12, 5'd3, 16'd1});
        consume();

        repeat (5) @(negedge clk);
        chk("startvar_cycles", sv_cyc, 8);
        chk("start_cycles", st_cyc, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
